uart_tx_fifo: RTL and testbench

Byte buffer and frame pacer upstream of the high-speed UART transmitter. Accepts bytes from the host logic at up to one per clock into a DEPTH-entry FIFO, then presents them to the UART one at a time as a single-cycle `tx_ready` pulse with `tx_send` valid. The UART exposes no busy flag, so this block spaces its pulses by a fixed frame time derived from the same clock/baud parameters the UART uses.

---
 rtl/uart_tx_fifo.sv | 133 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART that has no busy flag.
// Bytes are queued at up to one per clock and released as single-cycle
// tx_ready strobes, spaced by one UART frame time plus one clock of margin.
module uart_tx_fifo #(
    parameter int CLOCK_RATE   = 32000000,
    parameter int BAUD_RATE    = 921600,
    parameter int BIT_TIME     = CLOCK_RATE / BAUD_RATE,
    parameter int FRAME_CYCLES = 10 * BIT_TIME + 1,
    parameter int DEPTH_BITS   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    input  logic                  tx_enable,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   count,
    output logic                  overflow,
    output logic [7:0]            tx_send,
    output logic                  tx_ready,
    output logic                  busy
);

    localparam int                DEPTH     = 1 << DEPTH_BITS;
    // wait_cnt is 12 bits wide, so FRAME_CYCLES must stay below 4096.
    localparam logic [11:0]       WAIT_LAST = 12'(FRAME_CYCLES - 1);
    localparam logic [DEPTH_BITS:0] COUNT_FULL = (DEPTH_BITS + 1)'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [7:0]              r_mem [DEPTH];
    logic [DEPTH_BITS-1:0]   r_wr_ptr;
    logic [DEPTH_BITS-1:0]   r_rd_ptr;
    logic [DEPTH_BITS:0]     r_count;
    logic [11:0]             r_wait_cnt;
    logic                    r_overflow;
    logic                    r_tx_ready;
    logic [7:0]              r_tx_send;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_wait_done;

    assign full     = (r_count == COUNT_FULL);
    assign empty    = (r_count == '0);
    assign busy     = (r_state == ST_WAIT) || !empty;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign tx_send  = r_tx_send;
    assign tx_ready = r_tx_ready;

    // A write is accepted only against the registered full flag; a pop in the
    // same cycle does not make room for it.
    assign w_push      = wr_en && !full;
    assign w_wait_done = (r_wait_cnt == WAIT_LAST);

    // Pacer next-state: launch a frame from IDLE, hold WAIT for FRAME_CYCLES.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!empty && tx_enable) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_wait_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Storage array, written on accepted pushes; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and the registered overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= wr_en && full;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_BITS'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_BITS'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (DEPTH_BITS + 1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_BITS + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Pacer state, frame timer and the strobe/data presented to the UART.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_tx_ready <= 1'b0;
            r_tx_send  <= 8'h00;
        end else begin
            r_state    <= w_state_next;
            r_tx_ready <= w_pop;
            if (w_pop) begin
                r_tx_send  <= r_mem[r_rd_ptr];
                r_wait_cnt <= '0;
            end else if (r_state == ST_WAIT && !w_wait_done) begin
                r_wait_cnt <= r_wait_cnt + 12'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-and-timestamp model predicts every output
// each cycle; directed phases pin the model with literal expectations and a
// randomized phase exercises mixed traffic, flow control and resets.
module tb_uart_tx_fifo;

    localparam int FC    = 341;   // frame length in clocks at default parameters
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       tx_enable = 1'b0;
    logic       full, empty, overflow, tx_ready, busy;
    logic [4:0] count;
    logic [7:0] tx_send;

    uart_tx_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .tx_enable (tx_enable),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .tx_send   (tx_send),
        .tx_ready  (tx_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int ecount = 0;          // number of rising edges so far
    bit chk_en = 0;

    // Model: byte queue, last expected strobe/data/overflow, and the edge
    // index from which the pacer is idle again.
    byte unsigned m_q[$];
    logic [7:0]   m_send = 8'h00;
    logic         m_ready = 1'b0;
    logic         m_ovf = 1'b0;
    int           m_idle_from = 0;

    byte unsigned em_data[$];
    int           em_edge[$];
    int           ovf_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, ecount);
        end
    endtask

    // Model update on each rising edge from the inputs held since the last negedge.
    always @(posedge clk) begin : model
        bit idle;
        bit full_b;
        bit pop;
        ecount++;
        if (rst) begin
            idle   = (ecount - 1 >= m_idle_from);
            full_b = (m_q.size() == DEPTH);
            pop    = idle && (m_q.size() != 0) && tx_enable;
            m_ovf   = wr_en && full_b;
            m_ready = pop;
            if (pop) begin
                m_send      = m_q.pop_front();
                m_idle_from = ecount + FC;
            end
            if (wr_en && !full_b) m_q.push_back(wr_data);
        end
    end

    // Asynchronous reset empties the model immediately.
    always @(negedge rst) begin
        m_q.delete();
        m_ready     = 1'b0;
        m_send      = 8'h00;
        m_ovf       = 1'b0;
        m_idle_from = ecount;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx_ready", {31'd0, tx_ready}, {31'd0, m_ready});
            chk("tx_send", {24'd0, tx_send}, {24'd0, m_send});
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            chk("count", {27'd0, count}, m_q.size());
            chk("full", {31'd0, full}, (m_q.size() == DEPTH) ? 32'd1 : 32'd0);
            chk("empty", {31'd0, empty}, (m_q.size() == 0) ? 32'd1 : 32'd0);
            chk("busy", {31'd0, busy}, ((ecount < m_idle_from) || (m_q.size() != 0)) ? 32'd1 : 32'd0);
            if (tx_ready) begin
                $display("tx pulse edge=%0d data=0x%02h", ecount, tx_send);
                em_data.push_back(tx_send);
                em_edge.push_back(ecount);
            end
            if (overflow) ovf_seen++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pulses(input int target, input int budget, input string name);
        int i = 0;
        while (em_data.size() < target && i < budget) begin
            step();
            i++;
        end
        chk(name, em_data.size(), target);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int i = 0;
        while (busy && i < budget) begin
            step();
            i++;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd0);
        chk({tag, "_tx_send"}, {24'd0, tx_send}, 32'h00);
        chk({tag, "_empty"}, {31'd0, empty}, 32'd1);
        chk({tag, "_count"}, {27'd0, count}, 32'd0);
        chk({tag, "_full"}, {31'd0, full}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    endtask

    initial begin
        int base;
        int n_edge;
        int nxt;
        int ovf0;
        int guard;

        tx_enable = 1'b1;
        repeat (3) step();
        chk_reset_vals("por");
        rst = 1'b1;
        chk_en = 1;
        step();

        // Single byte: strobe one edge after the write edge, busy clears FC edges later.
        base = em_data.size();
        wr_en = 1'b1; wr_data = 8'hA5; n_edge = ecount + 1;
        step();
        wr_en = 1'b0;
        wait_pulses(base + 1, 20, "single_timeout");
        if (em_data.size() > base) begin
            chk("single_edge", em_edge[base], n_edge + 1);
            chk("single_data", {24'd0, em_data[base]}, 32'hA5);
            step();
            chk("single_width", {31'd0, tx_ready}, 32'd0);
            wait_idle(500, "single_busy_timeout");
            chk("single_busy_fall", ecount - em_edge[base], FC);
        end

        // Burst of three: strictly ordered, FC+1 clocks apart.
        base = em_data.size();
        wr_en = 1'b1; wr_data = 8'h01; step();
        wr_data = 8'h02; step();
        wr_data = 8'h03; step();
        wr_en = 1'b0;
        chk("burst_peak_count", {27'd0, count}, 32'd2);
        wait_pulses(base + 3, 3 * 342 + 50, "burst_timeout");
        if (em_data.size() >= base + 3) begin
            for (int i = 0; i < 3; i++) chk("burst_data", {24'd0, em_data[base + i]}, i + 1);
            chk("burst_gap1", em_edge[base + 1] - em_edge[base], 342);
            chk("burst_gap2", em_edge[base + 2] - em_edge[base + 1], 342);
        end
        wait_idle(500, "burst_busy_timeout");
        chk("burst_final_count", {27'd0, count}, 32'd0);

        // Overflow with flow control held off.
        tx_enable = 1'b0;
        step();
        ovf0 = ovf_seen;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
            if (i == 15) begin
                chk("ovf_full", {31'd0, full}, 32'd1);
                chk("ovf_count16", {27'd0, count}, 32'd16);
                chk("ovf_not_yet", {31'd0, overflow}, 32'd0);
            end
            if (i == 16) chk("ovf_pulse", {31'd0, overflow}, 32'd1);
        end
        wr_en = 1'b0;
        step();
        chk("ovf_pulse_end", {31'd0, overflow}, 32'd0);
        chk("ovf_once", ovf_seen - ovf0, 32'd1);
        base = em_data.size();
        tx_enable = 1'b1;
        wait_pulses(base + 16, 16 * 342 + 50, "ovf_drain_timeout");
        if (em_data.size() >= base + 16)
            for (int i = 0; i < 16; i++) chk("ovf_drain_data", {24'd0, em_data[base + i]}, i);
        repeat (400) step();
        chk("ovf_no_0x10", em_data.size() - base, 16);
        chk("ovf_empty", {31'd0, empty}, 32'd1);

        // Wrap/ordering: 40 bytes written whenever there is room.
        base = em_data.size();
        ovf0 = ovf_seen;
        nxt = 0;
        guard = 0;
        while (em_data.size() < base + 40 && guard < 40 * 342 + 500) begin
            if (nxt < 40 && !full) begin
                wr_en = 1'b1; wr_data = 8'(nxt); nxt++;
            end else begin
                wr_en = 1'b0;
            end
            step();
            guard++;
        end
        wr_en = 1'b0;
        chk("wrap_count", em_data.size() - base, 40);
        if (em_data.size() >= base + 40)
            for (int i = 0; i < 40; i++) chk("wrap_data", {24'd0, em_data[base + i]}, i);
        chk("wrap_no_overflow", ovf_seen - ovf0, 0);
        wait_idle(500, "wrap_busy_timeout");

        // Reset mid-WAIT with five bytes still queued.
        base = em_data.size();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'h40 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        wait_pulses(base + 1, 20, "midwait_first_timeout");
        chk("midwait_queued", {27'd0, count}, 32'd5);
        repeat (100) step();
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_reset_vals("async");
        step();
        rst = 1'b1;
        base = em_data.size();
        repeat (800) step();
        chk("midwait_silent", em_data.size() - base, 0);
        wr_en = 1'b1; wr_data = 8'hA1;
        step();
        wr_en = 1'b0;
        wait_pulses(base + 1, 20, "midwait_new_timeout");
        if (em_data.size() > base) chk("midwait_new_data", {24'd0, em_data[base]}, 32'hA1);
        wait_idle(500, "midwait_busy_timeout");

        // Randomized traffic, flow control toggling and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_data = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 59) == 0) tx_enable = ~tx_enable;
            if ($urandom_range(0, 1499) == 0) rst = 1'b0;
            else rst = 1'b1;
            step();
        end
        rst = 1'b1;
        wr_en = 1'b0;
        tx_enable = 1'b1;
        step();
        guard = 0;
        while (busy && guard < 17 * 342 + 50) begin
            step();
            guard++;
        end
        chk("final_drained", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
